// File: rtl/axi_ddr_mem_model.sv
// AXI4 slave memory standing in for DDR behind the L2 cache: one burst at a time, word-wide RAM.
// Define AXI_DDR_MEM_RANGE_CHECK_EN to answer out-of-range bursts with DECERR instead of wrapping.
module axi_ddr_mem_model #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 256,
  parameter int MEM_ADDR_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                axi_awid,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awlock,
  input  logic [3:0]          axi_awcache,
  input  logic [2:0]          axi_awprot,
  input  logic [3:0]          axi_awqos,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic                axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arlock,
  input  logic [3:0]          axi_arcache,
  input  logic [2:0]          axi_arprot,
  input  logic [3:0]          axi_arqos,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_ADDR_W;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA} state_t;

  state_t                r_state;
  logic [MEM_ADDR_W-1:0] r_idx;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic                  r_decerr;
  logic                  r_prio_rd;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [1:0]            r_rresp;
  logic [DATA_W-1:0]     r_rdata;
  logic [DATA_W-1:0]     r_ram_q;
  logic [DATA_W-1:0]     r_mem [DEPTH];

  logic                  w_idle, w_sel_rd, w_ar_hs, w_aw_hs, w_last, w_beat_err;
  logic                  w_mem_we, w_mem_re, w_aw_oor, w_ar_oor;
  logic [MEM_ADDR_W-1:0] w_aw_idx, w_ar_idx, w_idx_nxt, w_rd_idx;
  logic                  w_unused;

  assign w_idle     = (r_state == IDLE);
  assign w_sel_rd   = axi_arvalid & (~axi_awvalid | r_prio_rd);
  assign w_ar_hs    = w_idle & w_sel_rd;
  assign w_aw_hs    = w_idle & axi_awvalid & ~w_sel_rd;
  assign w_aw_idx   = axi_awaddr[OFF_W +: MEM_ADDR_W];
  assign w_ar_idx   = axi_araddr[OFF_W +: MEM_ADDR_W];
  assign w_last     = (r_cnt == r_len);
  assign w_beat_err = (axi_wlast != w_last);
  // WRAP bursts from the cache never cross a line, so they advance like INCR.
  assign w_idx_nxt  = (r_burst == 2'b00) ? r_idx : r_idx + MEM_ADDR_W'(1);

`ifdef AXI_DDR_MEM_RANGE_CHECK_EN
  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr, input logic [7:0] len);
    logic [ADDR_W-1:0] hi;
    logic [31:0]       end_w;
    hi    = addr >> (OFF_W + MEM_ADDR_W);
    end_w = 32'(addr[OFF_W +: MEM_ADDR_W]) + 32'(len);
    return (hi != '0) || (end_w >= 32'(DEPTH));
  endfunction

  assign w_aw_oor = out_of_range(axi_awaddr, axi_awlen);
  assign w_ar_oor = out_of_range(axi_araddr, axi_arlen);
`else
  assign w_aw_oor = 1'b0;
  assign w_ar_oor = 1'b0;
`endif

  assign w_mem_we = (r_state == WR_DATA) & axi_wvalid & ~r_decerr & ~rst;
  assign w_mem_re = w_ar_hs | ((r_state == RD_DATA) & axi_rready & ~w_last);
  assign w_rd_idx = w_ar_hs ? w_ar_idx : w_idx_nxt;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi_wstrb[b]) r_mem[r_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
    if (w_mem_re) r_ram_q <= r_mem[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_prio_rd <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ar_hs) begin
            r_idx     <= w_ar_idx;
            r_len     <= axi_arlen;
            r_burst   <= axi_arburst;
            r_cnt     <= 8'd0;
            r_decerr  <= w_ar_oor;
            r_prio_rd <= 1'b0;
            r_state   <= RD_FETCH;
          end else if (w_aw_hs) begin
            r_idx     <= w_aw_idx;
            r_len     <= axi_awlen;
            r_burst   <= axi_awburst;
            r_cnt     <= 8'd0;
            r_err     <= 1'b0;
            r_decerr  <= w_aw_oor;
            r_prio_rd <= 1'b1;
            r_wready  <= 1'b1;
            r_state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (axi_wvalid) begin
            r_idx <= w_idx_nxt;
            r_cnt <= r_cnt + 8'd1;
            if (w_beat_err) r_err <= 1'b1;
            // Burst length comes from awlen alone; a misplaced wlast only flags SLVERR.
            if (w_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= r_decerr ? 2'b11 : ((r_err | w_beat_err) ? 2'b10 : 2'b00);
              r_state  <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (axi_bready) begin
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
            r_state  <= IDLE;
          end
        end
        RD_FETCH: begin
          r_rdata  <= r_decerr ? '0 : r_ram_q;
          r_rresp  <= r_decerr ? 2'b11 : 2'b00;
          r_rlast  <= w_last;
          r_rvalid <= 1'b1;
          r_state  <= RD_DATA;
        end
        RD_DATA: begin
          if (axi_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_idx   <= w_idx_nxt;
              r_cnt   <= r_cnt + 8'd1;
              r_state <= RD_FETCH;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign axi_awready = w_aw_hs;
  assign axi_arready = w_ar_hs;
  assign axi_wready  = r_wready;
  assign axi_bvalid  = r_bvalid;
  assign axi_bresp   = r_bresp;
  assign axi_rvalid  = r_rvalid;
  assign axi_rlast   = r_rlast;
  assign axi_rresp   = r_rresp;
  assign axi_rdata   = r_rdata;

  assign w_unused = ^{axi_awid, axi_awsize, axi_awlock, axi_awcache, axi_awprot, axi_awqos,
                      axi_arid, axi_arsize, axi_arlock, axi_arcache, axi_arprot, axi_arqos,
                      axi_awaddr, axi_araddr};

endmodule

// File: tb/tb_axi_ddr_mem_model.sv
// Directed bench for axi_ddr_mem_model: single-beat vector table plus burst, arbitration and reset sequences.
// Covers both builds; AXI_DDR_MEM_RANGE_CHECK_EN selects the DECERR expectations.
module tb_axi_ddr_mem_model;
  localparam int ADDR_W     = 30;
  localparam int DATA_W     = 256;
  localparam int MEM_ADDR_W = 14;
  localparam int STRB_W     = DATA_W / 8;

  logic              clk, rst;
  logic              axi_awid, axi_awlock, axi_awvalid, axi_awready;
  logic [ADDR_W-1:0] axi_awaddr, axi_araddr;
  logic [7:0]        axi_awlen, axi_arlen;
  logic [2:0]        axi_awsize, axi_awprot, axi_arsize, axi_arprot;
  logic [1:0]        axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic [3:0]        axi_awcache, axi_awqos, axi_arcache, axi_arqos;
  logic [DATA_W-1:0] axi_wdata, axi_rdata;
  logic [STRB_W-1:0] axi_wstrb;
  logic              axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic              axi_arid, axi_arlock, axi_arvalid, axi_arready;
  logic              axi_rlast, axi_rvalid, axi_rready;

  axi_ddr_mem_model #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
    .axi_awprot(axi_awprot), .axi_awqos(axi_awqos), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_arqos(axi_arqos), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic              is_rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic [1:0]        resp;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t              tbl [9];
  int                n_cmp = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] wbeat [8];
  logic [DATA_W-1:0] exp_rd [8];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, DATA_W'(act), DATA_W'(exp));
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    chk(name, DATA_W'(act), DATA_W'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [STRB_W-1:0] strb, input int wlast_at, input logic [1:0] exp_resp,
                          input string tag);
    int n;
    axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awvalid = 1'b1;
    #1;
    n = 0;
    while (!axi_awready && n < 50) begin tick(); n++; end
    if (!axi_awready) chkb($sformatf("%s_aw_timeout", tag), 1'b0, 1'b1);
    tick();
    axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      axi_wdata = wbeat[b]; axi_wstrb = strb; axi_wlast = (b == wlast_at); axi_wvalid = 1'b1;
      #1;
      n = 0;
      while (!axi_wready && n < 50) begin tick(); n++; end
      if (!axi_wready) chkb($sformatf("%s_w%0d_timeout", tag, b), 1'b0, 1'b1);
      tick();
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    chkb($sformatf("%s_bvalid_1cyc", tag), axi_bvalid, 1'b1);
    n = 0;
    while (!axi_bvalid && n < 50) begin tick(); n++; end
    chk2($sformatf("%s_bresp", tag), axi_bresp, exp_resp);
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    chkb($sformatf("%s_bvalid_drop", tag), axi_bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [1:0] exp_resp, input int stall_beat, input int stall_n,
                         input string tag);
    int n, lat;
    axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arvalid = 1'b1; axi_rready = 1'b1;
    #1;
    n = 0;
    while (!axi_arready && n < 50) begin tick(); n++; end
    if (!axi_arready) chkb($sformatf("%s_ar_timeout", tag), 1'b0, 1'b1);
    tick();
    axi_arvalid = 1'b0;
    lat = 1;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!axi_rvalid && n < 50) begin tick(); n++; lat++; end
      if (b == 0) chk($sformatf("%s_ar_to_rvalid", tag), DATA_W'(lat), DATA_W'(2));
      chkb($sformatf("%s_rvalid%0d", tag, b), axi_rvalid, 1'b1);
      chk($sformatf("%s_rdata%0d", tag, b), axi_rdata, exp_rd[b]);
      chk2($sformatf("%s_rresp%0d", tag, b), axi_rresp, exp_resp);
      chkb($sformatf("%s_rlast%0d", tag, b), axi_rlast, b == int'(len));
      if (b == stall_beat) begin
        axi_rready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chkb($sformatf("%s_stall%0d_rvalid", tag, s), axi_rvalid, 1'b1);
          chk($sformatf("%s_stall%0d_rdata", tag, s), axi_rdata, exp_rd[b]);
        end
        axi_rready = 1'b1;
        #1;
      end
      tick();
    end
    chkb($sformatf("%s_rvalid_end", tag), axi_rvalid, 1'b0);
    axi_rready = 1'b0;
  endtask

  initial begin
    int n;
    {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awcache,
     axi_awprot, axi_awqos, axi_awvalid} = '0;
    {axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready} = '0;
    {axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache,
     axi_arprot, axi_arqos, axi_arvalid, axi_rready} = '0;
    axi_awsize = 3'd5; axi_arsize = 3'd5;

    tbl[0] = '{1'b0, 30'h000A0, {32{8'hAA}}, 32'hFFFF_FFFF, 2'b00, '0};
    tbl[1] = '{1'b0, 30'h000A0, {32{8'h11}}, 32'h0000_000F, 2'b00, '0};
    tbl[2] = '{1'b1, 30'h000A0, '0, '0, 2'b00, {{28{8'hAA}}, {4{8'h11}}}};
    tbl[3] = '{1'b0, 30'h00060, {32{8'h00}}, 32'hFFFF_FFFF, 2'b00, '0};
    tbl[4] = '{1'b0, 30'h00060, {32{8'h5C}}, 32'hFFFF_0000, 2'b00, '0};
    tbl[5] = '{1'b1, 30'h00060, '0, '0, 2'b00, {{16{8'h5C}}, {16{8'h00}}}};
`ifdef AXI_DDR_MEM_RANGE_CHECK_EN
    tbl[6] = '{1'b0, 30'h800A0, {32{8'h77}}, 32'h8000_0000, 2'b11, '0};
    tbl[7] = '{1'b1, 30'h000BF, '0, '0, 2'b00, {{28{8'hAA}}, {4{8'h11}}}};
    tbl[8] = '{1'b1, 30'h800A0, '0, '0, 2'b11, '0};
`else
    tbl[6] = '{1'b0, 30'h800A0, {32{8'h77}}, 32'h8000_0000, 2'b00, '0};
    tbl[7] = '{1'b1, 30'h000BF, '0, '0, 2'b00, {8'h77, {27{8'hAA}}, {4{8'h11}}}};
    tbl[8] = '{1'b1, 30'h800A0, '0, '0, 2'b00, {8'h77, {27{8'hAA}}, {4{8'h11}}}};
`endif

    rst = 1'b1;
    repeat (3) tick();
    chkb("rst_awready", axi_awready, 1'b0);
    chkb("rst_arready", axi_arready, 1'b0);
    chkb("rst_wready", axi_wready, 1'b0);
    chkb("rst_bvalid", axi_bvalid, 1'b0);
    chkb("rst_rvalid", axi_rvalid, 1'b0);
    chkb("rst_rlast", axi_rlast, 1'b0);
    chk2("rst_bresp", axi_bresp, 2'b00);
    chk2("rst_rresp", axi_rresp, 2'b00);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].is_rd) begin
        exp_rd[0] = tbl[i].exp;
        do_read(tbl[i].addr, 8'd0, 2'b01, tbl[i].resp, -1, 0, $sformatf("vec%0d", i));
      end else begin
        wbeat[0] = tbl[i].data;
        do_write(tbl[i].addr, 8'd0, 2'b01, tbl[i].strb, 0, tbl[i].resp, $sformatf("vec%0d", i));
      end
    end

    // INCR line write and readback, then the same read with a 5-cycle rready stall
    for (int i = 0; i < 4; i++) begin
      wbeat[i]  = {8{32'hC0DE_0000 + 32'(i)}};
      exp_rd[i] = wbeat[i];
    end
    do_write(30'h40, 8'd3, 2'b01, '1, 3, 2'b00, "incr_wr");
    do_read(30'h40, 8'd3, 2'b01, 2'b00, -1, 0, "incr_rd");
    do_read(30'h40, 8'd3, 2'b01, 2'b00, 1, 5, "stall_rd");

    // wlast on beat 1 of a 4-beat burst: all four beats land, SLVERR
    for (int i = 0; i < 4; i++) begin
      wbeat[i]  = {8{32'hBEEF_0000 + 32'(i)}};
      exp_rd[i] = wbeat[i];
    end
    do_write(30'h400, 8'd3, 2'b01, '1, 1, 2'b10, "early_wlast");
    do_read(30'h400, 8'd3, 2'b01, 2'b00, -1, 0, "early_wlast_rd");

    // FIXED burst: only word 8 changes, holding the last beat
    wbeat[0] = {32{8'h99}};
    do_write(30'h120, 8'd0, 2'b01, '1, 0, 2'b00, "pre_w9");
    wbeat[0] = {32{8'hE0}}; wbeat[1] = {32{8'hE1}}; wbeat[2] = {32{8'hE2}};
    do_write(30'h100, 8'd2, 2'b00, '1, 2, 2'b00, "fixed_wr");
    exp_rd[0] = {32{8'hE2}}; exp_rd[1] = {32{8'h99}};
    do_read(30'h100, 8'd1, 2'b01, 2'b00, -1, 0, "fixed_rd");

    // Last word with arlen=1: wraps to word 0, or DECERR with range checking
    wbeat[0] = {32{8'h3C}};
    do_write(30'h7FFE0, 8'd0, 2'b01, '1, 0, 2'b00, "pre_last");
    wbeat[0] = {32{8'hC3}};
    do_write(30'h0, 8'd0, 2'b01, '1, 0, 2'b00, "pre_w0");
`ifdef AXI_DDR_MEM_RANGE_CHECK_EN
    exp_rd[0] = '0; exp_rd[1] = '0;
    do_read(30'h7FFE0, 8'd1, 2'b01, 2'b11, -1, 0, "range_rd");
`else
    exp_rd[0] = {32{8'h3C}}; exp_rd[1] = {32{8'hC3}};
    do_read(30'h7FFE0, 8'd1, 2'b01, 2'b00, -1, 0, "wrap_rd");
`endif

    // Arbitration from reset: write first, then read wins the next tie
    rst = 1'b1;
    tick();
    rst = 1'b0;
    axi_awaddr = 30'h200; axi_awlen = 8'd0; axi_awburst = 2'b01; axi_awvalid = 1'b1;
    axi_araddr = 30'h200; axi_arlen = 8'd0; axi_arburst = 2'b01; axi_arvalid = 1'b1;
    #1;
    chkb("arb1_awready", axi_awready, 1'b1);
    chkb("arb1_arready", axi_arready, 1'b0);
    axi_arvalid = 1'b0;
    wbeat[0] = {16{16'h5A5A}};
    do_write(30'h200, 8'd0, 2'b01, '1, 0, 2'b00, "arb_wr");
    axi_awvalid = 1'b1; axi_arvalid = 1'b1;
    #1;
    chkb("arb2_arready", axi_arready, 1'b1);
    chkb("arb2_awready", axi_awready, 1'b0);
    axi_awvalid = 1'b0;
    exp_rd[0] = {16{16'h5A5A}};
    do_read(30'h200, 8'd0, 2'b01, 2'b00, -1, 0, "arb_rd");

    // Reset while a read beat is presented, then a fresh read from IDLE
    axi_araddr = 30'h40; axi_arlen = 8'd3; axi_arburst = 2'b01; axi_arvalid = 1'b1; axi_rready = 1'b0;
    #1;
    n = 0;
    while (!axi_arready && n < 50) begin tick(); n++; end
    tick();
    axi_arvalid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < 50) begin tick(); n++; end
    chk("rstrd_beat0", axi_rdata, {8{32'hC0DE_0000}});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkb("rstrd_rvalid", axi_rvalid, 1'b0);
    chkb("rstrd_rlast", axi_rlast, 1'b0);
    axi_arvalid = 1'b1;
    #1;
    chkb("rstrd_arready", axi_arready, 1'b1);
    axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) exp_rd[i] = {8{32'hC0DE_0000 + 32'(i)}};
    do_read(30'h40, 8'd3, 2'b01, 2'b00, -1, 0, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_ddr_mem_model.md
Name: axi_ddr_mem_model

Overview:
- AXI4 slave memory that sits directly downstream of the external-memory L2 cache AXI master.
- Consumes the cache's line-fill read bursts and write-back write bursts, storing data in an internal word-wide RAM.
- Used as the DDR stand-in for simulation and for FPGA builds without DDR; port-compatible with the cache's AXI master.
- One transaction in flight at a time, with read/write arbitration and byte-strobed writes.

Parameters:
- ADDR_W, 30, AXI byte-address width (matches DDR address width).
- DATA_W, 256, AXI data width in bits (matches MIG bus width); must be a power of 2, at least 32.
- MEM_ADDR_W, 14, log2 of RAM depth in DATA_W-bit words.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- axi_awid  in  1  write ID (ignored)
- axi_awaddr  in  ADDR_W  write byte address
- axi_awlen  in  8  write beats minus 1
- axi_awsize  in  3  beat size (ignored; full-width beats assumed)
- axi_awburst  in  2  burst type
- axi_awlock/axi_awcache/axi_awprot/axi_awqos  in  1/4/3/4  ignored
- axi_awvalid  in  1;  axi_awready  out  1
- axi_wdata  in  DATA_W;  axi_wstrb  in  DATA_W/8;  axi_wlast  in  1;  axi_wvalid  in  1;  axi_wready  out  1
- axi_bresp  out  2;  axi_bvalid  out  1;  axi_bready  in  1
- axi_arid  in  1 (ignored);  axi_araddr  in  ADDR_W;  axi_arlen  in  8;  axi_arsize  in  3 (ignored);  axi_arburst  in  2
- axi_arlock/axi_arcache/axi_arprot/axi_arqos  in  1/4/3/4  ignored
- axi_arvalid  in  1;  axi_arready  out  1
- axi_rdata  out  DATA_W;  axi_rresp  out  2;  axi_rlast  out  1;  axi_rvalid  out  1;  axi_rready  in  1

Behaviour:
- Single clock; reset is synchronous and active-high on rst.
- Reset: state IDLE; awready, arready, wready, bvalid, rvalid, rlast = 0; bresp = rresp = 0; prio_rd = 0. RAM contents are not cleared.
- Reset mid-burst abandons the burst immediately; partially written beats remain in RAM.
- Word index = addr[MEM_ADDR_W+log2(DATA_W/8)-1 : log2(DATA_W/8)]. Upper bits are ignored; the index wraps modulo 2^MEM_ADDR_W.
- Burst: FIXED (00) keeps the index constant. INCR (01) and WRAP (10) both increment by 1 per beat (WRAP is treated as INCR).
- FSM states: IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA.
- IDLE arbitration:
  - sel_rd = arvalid & (~awvalid | prio_rd).
  - arready = (state==IDLE) & sel_rd.
  - awready = (state==IDLE) & awvalid & ~sel_rd (combinational).
- AW handshake: latch index, awlen, awburst; clear beat counter and err flag; prio_rd <= 1; go to WR_DATA.
- WR_DATA:
  - wready = 1.
  - Each wvalid beat writes RAM[index] byte-wise per wstrb, then advances index and counter.
  - err flag sets if wlast != (cnt==len) on any beat.
  - The beat with cnt==len goes to WR_RESP. Burst length is always len+1 beats regardless of wlast.
- WR_RESP: bvalid = 1; bresp = err ? 2'b10 : 2'b00. Held until bready, then go to IDLE.
- AR handshake: latch fields; prio_rd <= 0; issue RAM read of the first index; go to RD_FETCH.
- RD_FETCH: one cycle for the synchronous RAM read; rdata is captured into the output register; go to RD_DATA.
- RD_DATA:
  - rvalid = 1; rlast = (cnt==len); rresp = 00.
  - rdata stays stable until rready.
  - On rready, the last beat goes to IDLE. Otherwise increment, issue the next read, and go to RD_FETCH.
  - Throughput is 1 beat per 2 cycles.
- Latency: AR handshake to first rvalid = 2 cycles. Last W beat to bvalid = 1 cycle.
- bvalid and rvalid never drop without their ready. IDLE re-arbitrates the cycle after a transaction completes.

Optional Feature:
- Macro: AXI_DDR_MEM_RANGE_CHECK_EN.
- Defined: any burst whose start word or end word (start+len) is ≥ 2^MEM_ADDR_W, or whose address bits above the index are nonzero, is answered with DECERR (2'b11).
  - Writes: beats are consumed without being stored; bresp = 11.
  - Reads: len+1 beats are returned with rdata = 0 and rresp = 11.
- Undefined: no check; index wrap-around as described in Behaviour.

Test Plan:
- Write INCR awaddr=0x40, awlen=3, 4 beats of distinct data with wstrb all-1, wlast on beat 3 -> bresp=00 one cycle after the last beat. Read back araddr=0x40, arlen=3 -> 4 beats matching the written data, rlast only on the 4th beat.
- Partial strobe: word 5 preloaded with 0xAA..AA; write with wstrb=0x0000000F, data 0x11..11 -> readback has bytes 0-3 = 0x11 and the remaining bytes = 0xAA.
- awvalid and arvalid asserted in the same cycle from reset -> write served first. Next simultaneous request -> read served first (alternates).
- wlast asserted on beat 1 of an awlen=3 burst -> 4 beats are still accepted, bresp=10. rready held low for 5 cycles mid-read -> rdata/rvalid stable, no beat lost.
- FIXED burst with awlen=2 -> only one word is written (the last beat's data). rst pulsed during RD_DATA -> rvalid=0 next cycle, and a new AR is accepted from IDLE.
- With AXI_DDR_MEM_RANGE_CHECK_EN: araddr = last word, arlen=1 -> 2 beats with rresp=11 and rdata=0.
